// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-way stream multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Returns at least 1, so a select port never collapses to zero width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 32'd0;
    while ((32'd1 << r) < n) r++;
    return (r == 32'd0) ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  int   w_dist;
  int   w_best;
  logic w_found;

  // Lowest rotated distance from ptr wins; distance N means nothing granted.
  always_comb begin
    w_found = 1'b0;
    w_best  = int'(N);
    w_dist  = 0;
    gnt_idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_dist = (i + int'(N) - int'(ptr)) % int'(N);
      if (en && req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        gnt_idx = SEL_W'(i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < int'(N); i++) begin
      gnt[i] = w_found && (gnt_idx == SEL_W'(i));
    end
  end

endmodule

// File: rtl/stream_mux_nway.sv
// N-input registered stream multiplexer with fixed-select or round-robin channel choice.
module stream_mux_nway
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SEL_W-1:0]     out_src,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_out_src;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_can_load;
  logic             w_xfer;
  logic [N-1:0]     w_fix_gnt;
  logic [N-1:0]     w_rr_gnt;
  logic [SEL_W-1:0] w_rr_idx;
  logic [N-1:0]     w_gnt;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [WIDTH-1:0] w_mux_data;
  logic [SEL_W-1:0] w_ptr_next;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_rr_arbiter (
    .req     (in_valid),
    .ptr     (r_rr_ptr),
    .en      (mode == MODE_RR),
    .gnt     (w_rr_gnt),
    .gnt_idx (w_rr_idx)
  );

  // An out-of-range sel matches no channel, so nothing is granted.
  always_comb begin
    w_fix_gnt = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_fix_gnt[i] = in_valid[i] && (sel == SEL_W'(i));
    end
  end

  assign w_gnt      = (mode == MODE_RR) ? w_rr_gnt : w_fix_gnt;
  assign w_gnt_idx  = (mode == MODE_RR) ? w_rr_idx : sel;
  assign w_can_load = !r_out_valid || out_ready;
  assign w_xfer     = (|w_gnt) && w_can_load;
  assign in_ready   = rst_n ? (w_gnt & {N{w_can_load}}) : '0;

  always_comb begin
    w_mux_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w_gnt[i]) w_mux_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign w_ptr_next = (w_gnt_idx == SEL_W'(N - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_src   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_xfer) begin
      r_out_data  <= w_mux_data;
      r_out_valid <= 1'b1;
      r_out_src   <= w_gnt_idx;
      if (mode == MODE_RR) r_rr_ptr <= w_ptr_next;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_stream_mux_nway.sv
// Self-checking bench for stream_mux_nway: directed scenarios plus randomized traffic vs a model.
module tb_stream_mux_nway;

  localparam int WIDTH = 8;
  localparam int N     = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic             mode;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [1:0]       out_src;
  logic             out_ready;

  // Second instance with N=5 so an out-of-range sel is representable.
  logic [39:0]      in_data2;
  logic [4:0]       in_valid2;
  logic [4:0]       in_ready2;
  logic             mode2;
  logic [2:0]       sel2;
  logic [7:0]       out_data2;
  logic             out_valid2;
  logic [2:0]       out_src2;
  logic             out_ready2;

  int checks = 0;
  int errors = 0;

  // Reference model state: the word held at the output and the round-robin start.
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_src;
  int               m_ptr;

  always #5 clk = ~clk;

  stream_mux_nway #(
    .WIDTH (WIDTH),
    .N     (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  stream_mux_nway #(
    .WIDTH (8),
    .N     (5)
  ) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .mode      (mode2),
    .sel       (sel2),
    .out_data  (out_data2),
    .out_valid (out_valid2),
    .out_src   (out_src2),
    .out_ready (out_ready2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_ptr   = 0;
  endtask

  // Channel the rules say should be served now, or -1 for none.
  function automatic int model_pick();
    int c;
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // Entered at a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input string tag);
    int         p;
    logic [3:0] exp_rdy;
    logic       can_load;
    #1;
    p        = model_pick();
    can_load = !m_valid || out_ready;
    exp_rdy  = '0;
    if (rst_n && p >= 0 && can_load) exp_rdy = 4'(32'd1 << p);
    check({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (exp_rdy != 4'd0) begin
      m_valid = 1'b1;
      m_data  = in_data[p*WIDTH +: WIDTH];
      m_src   = p;
      if (mode) m_ptr = (p + 1) % N;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check({tag, " out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, " out_src"}, 32'(out_src), 32'(m_src));
    check({tag, " out_data"}, 32'(out_data), 32'(m_data));
    @(negedge clk);
  endtask

  initial begin
    int exp_seq[6];
    exp_seq = '{0, 1, 2, 3, 0, 1};

    rst_n      = 1'b0;
    mode       = 1'b1;
    sel        = 2'd0;
    out_ready  = 1'b1;
    in_valid   = 4'hF;
    in_data    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    mode2      = 1'b0;
    sel2       = 3'd5;
    in_valid2  = 5'h1F;
    in_data2   = {8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hB0};
    out_ready2 = 1'b1;
    m_reset();

    // Reset with every channel requesting.
    repeat (2) @(negedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_data", 32'(out_data), 32'h0);
    check("reset out_src", 32'(out_src), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin, all valid: no bubbles, sources in order from ch0.
    for (int k = 0; k < 6; k++) begin
      step("rr_all");
      check("rr_seq src", 32'(out_src), 32'(exp_seq[k]));
      check("rr_seq valid", 32'(out_valid), 32'h1);
    end

    // Fixed select on channel 2.
    mode = 1'b0;
    sel  = 2'd2;
    for (int k = 0; k < 4; k++) begin
      step("fixed");
      check("fixed data", 32'(out_data), 32'hA2);
      check("n5 oor in_ready", 32'(in_ready2), 32'h0);
      check("n5 oor out_valid", 32'(out_valid2), 32'h0);
    end
    sel2 = 3'd4;
    #1;
    check("n5 sel4 in_ready", 32'(in_ready2), 32'h10);

    // Round-robin with only ch1 and ch3, then ch3 drops out.
    mode     = 1'b1;
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) step("rr_13");
    in_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      step("rr_1");
      check("rr_1 src", 32'(out_src), 32'h1);
    end

    // Backpressure: load, stall three cycles, then drain and reload together.
    in_valid  = 4'hF;
    out_ready = 1'b1;
    step("bp_load");
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step("bp_hold");
      check("bp_hold in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    step("bp_release");
    check("bp_release valid", 32'(out_valid), 32'h1);

    // Asynchronous reset while a stalled word is held.
    out_ready = 1'b0;
    step("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check("async out_valid", 32'(out_valid), 32'h0);
    check("async in_ready", 32'(in_ready), 32'h0);
    m_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step("post_reset");
    check("post_reset src", 32'(out_src), 32'h0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      in_valid  = 4'($urandom);
      in_data   = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      if ((k % 8) == 0) mode = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
